// File: rtl/ha_serial_sched_if.sv
// Request/result bundle for the shared bit-serial adder scheduler.
// The master side drives requests and consumes results; the slave side is the scheduler.
interface ha_serial_sched_if #(
  parameter int W = 8
) ();
  logic [1:0]     req_valid;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     req_ready;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_sum;
  logic           res_cout;
  logic           res_id;
  logic           busy;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_id, busy
  );
endinterface

// File: rtl/ha_serial_sched.sv
// Round-robin scheduler sharing one bit-serial half-adder pair between two requesters.
// The sum is built LSB-first over W cycles and the result is handed off with valid/ready.
module ha_serial_sched #(
  parameter int W = 8
) (
  input logic               clk,
  input logic               rst,
  ha_serial_sched_if.slave  bus
);

  // state | meaning
  // IDLE  | arbitrate, pulse req_ready to the winner and capture its operands
  // RUN   | one sum bit per clock, LSB first, W cycles
  // DONE  | result valid, held until res_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = 5;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_sr, b_sr, sum_sr, sum_shift, sum_q;
  logic          carry, carry_nx, bit_s, ha1_s;
  logic          cout_q, id_q, last;
  logic          grant, accept, finish;
  logic [1:0]    req_ready_c;

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant = bus.req_valid[1];
    if (bus.req_valid == 2'b11) grant = ~last;
  end

  assign ha1_s    = a_sr[0] ^ b_sr[0];
  assign bit_s    = ha1_s ^ carry;
  assign carry_nx = (a_sr[0] & b_sr[0]) | (ha1_s & carry);

  generate
    if (W == 1) begin : g_narrow
      assign sum_shift = bit_s;
    end else begin : g_wide
      assign sum_shift = {bit_s, sum_sr[W-1:1]};
    end
  endgenerate

  always_comb begin
    state_nx    = state;
    req_ready_c = 2'b00;
    accept      = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c = grant ? 2'b10 : 2'b01;
          accept      = 1'b1;
          state_nx    = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The shift register is separate from the result register so res_sum stays put during the next op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      id_q   <= 1'b0;
      last   <= 1'b1;
    end else if (accept) begin
      a_sr   <= grant ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
      b_sr   <= grant ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      id_q   <= grant;
      last   <= grant;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_shift;
      carry  <= carry_nx;
      cnt    <= cnt + 5'd1;
      if (finish) begin
        sum_q  <= sum_shift;
        cout_q <= carry_nx;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.res_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_id    = id_q;

endmodule

// File: tb/tb_ha_serial_sched.sv
// Directed bench for ha_serial_sched: W=8 instance for the main sequence, W=1 instance for the edge case.
module tb_ha_serial_sched;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  ha_serial_sched_if #(.W(8)) bus8 ();
  ha_serial_sched_if #(.W(1)) bus1 ();

  ha_serial_sched #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  ha_serial_sched #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [1:0] rv, input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1, input bit keep,
                          output logic [1:0] rr);
    bus8.req_valid = rv;
    bus8.req_a     = {a1, a0};
    bus8.req_b     = {b1, b0};
    #1 rr = bus8.req_ready;
    @(negedge clk);
    if (!keep) bus8.req_valid = 2'b00;
  endtask

  task automatic wait_valid(output int lat, output int bcnt);
    lat  = 0;
    bcnt = int'(bus8.busy);
    while (!bus8.res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      bcnt += int'(bus8.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] rr;
    int         lat, bcnt;
    logic [7:0] exp_sum;
    logic       exp_cout;

    rst = 1'b1;
    bus8.req_valid = 2'b00; bus8.req_a = '0; bus8.req_b = '0; bus8.res_ready = 1'b1;
    bus1.req_valid = 2'b00; bus1.req_a = '0; bus1.req_b = '0; bus1.res_ready = 1'b1;
    #12;
    chk("rst_res_valid", bus8.res_valid, 0);
    chk("rst_res_sum",   bus8.res_sum,   0);
    chk("rst_res_cout",  bus8.res_cout,  0);
    chk("rst_res_id",    bus8.res_id,    0);
    chk("rst_req_ready", bus8.req_ready, 0);
    chk("rst_busy",      bus8.busy,      0);
    @(negedge clk);
    rst = 1'b0;

    // Requester 0 alone: 0x5A + 0x3C = 0x96
    start_op(2'b01, 8'h5A, 8'h3C, 8'h00, 8'h00, 1'b0, rr);
    chk("op1_req_ready", rr, 2'b01);
    chk("op1_ready_pulse", bus8.req_ready, 2'b00);
    wait_valid(lat, bcnt);
    chk("op1_latency", lat, 8);
    chk("op1_sum",  bus8.res_sum,  8'h96);
    chk("op1_cout", bus8.res_cout, 0);
    chk("op1_id",   bus8.res_id,   0);
    @(negedge clk);
    chk("op1_busy_cycles", bcnt, 9);
    chk("op1_idle_after", bus8.busy, 0);

    // Requester 1 alone: 0xFF + 0x01 wraps with carry
    start_op(2'b10, 8'h00, 8'h00, 8'hFF, 8'h01, 1'b0, rr);
    chk("op2_req_ready", rr, 2'b10);
    wait_valid(lat, bcnt);
    chk("op2_sum",  bus8.res_sum,  8'h00);
    chk("op2_cout", bus8.res_cout, 1);
    chk("op2_id",   bus8.res_id,   1);
    @(negedge clk);

    // Both held: 0x11+0x22=0x33 (id 0), 0xF0+0x20=0x110 (id 1); grants alternate
    for (int k = 0; k < 4; k++) begin
      start_op(2'b11, 8'h11, 8'h22, 8'hF0, 8'h20, 1'b1, rr);
      chk("rr_req_ready", rr, (k % 2 == 1) ? 2'b10 : 2'b01);
      wait_valid(lat, bcnt);
      exp_sum  = (k % 2 == 1) ? 8'h10 : 8'h33;
      exp_cout = (k % 2 == 1);
      chk("rr_id",   bus8.res_id,   k % 2);
      chk("rr_sum",  bus8.res_sum,  exp_sum);
      chk("rr_cout", bus8.res_cout, exp_cout);
      @(negedge clk);
    end
    bus8.req_valid = 2'b00;

    // Backpressure: 0xC3 + 0x5A = 0x11D held while res_ready is low
    bus8.res_ready = 1'b0;
    start_op(2'b10, 8'h00, 8'h00, 8'hC3, 8'h5A, 1'b0, rr);
    wait_valid(lat, bcnt);
    chk("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      bus8.req_valid = 2'b11;
      bus8.req_a = ~bus8.req_a;
      bus8.req_b = ~bus8.req_b;
      #1;
      chk("bp_valid",     bus8.res_valid, 1);
      chk("bp_sum",       bus8.res_sum,   8'h1D);
      chk("bp_cout",      bus8.res_cout,  1);
      chk("bp_req_ready", bus8.req_ready, 2'b00);
      @(negedge clk);
    end
    bus8.req_valid = 2'b00;
    bus8.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_consumed_valid", bus8.res_valid, 0);
    chk("bp_consumed_busy",  bus8.busy,      0);
    chk("bp_sum_held",       bus8.res_sum,   8'h1D);

    // Abort mid-RUN: requester 0 accepted (pointer now 0), reset on cycle 3
    start_op(2'b01, 8'h0F, 8'h01, 8'h00, 8'h00, 1'b0, rr);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_pre", bus8.busy,    1);
    chk("abort_sum_pre",  bus8.res_sum, 8'h1D);
    #2 rst = 1'b1;
    #1;
    chk("abort_res_valid", bus8.res_valid, 0);
    chk("abort_res_sum",   bus8.res_sum,   0);
    chk("abort_res_cout",  bus8.res_cout,  0);
    chk("abort_res_id",    bus8.res_id,    0);
    chk("abort_busy",      bus8.busy,      0);
    chk("abort_req_ready", bus8.req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    start_op(2'b11, 8'h01, 8'h02, 8'h40, 8'h40, 1'b0, rr);
    chk("post_rst_grant", rr, 2'b01);
    wait_valid(lat, bcnt);
    chk("post_rst_id",  bus8.res_id,  0);
    chk("post_rst_sum", bus8.res_sum, 8'h03);
    @(negedge clk);

    // W=1: 1+1 -> sum 0 carry 1; 1+0 -> sum 1 carry 0
    bus1.req_valid = 2'b01; bus1.req_a = 2'b01; bus1.req_b = 2'b01;
    #1 chk("w1_req_ready", bus1.req_ready, 2'b01);
    @(negedge clk);
    bus1.req_valid = 2'b00;
    chk("w1_run_valid", bus1.res_valid, 0);
    chk("w1_run_busy",  bus1.busy,      1);
    @(negedge clk);
    chk("w1a_valid", bus1.res_valid, 1);
    chk("w1a_sum",   bus1.res_sum,   0);
    chk("w1a_cout",  bus1.res_cout,  1);
    @(negedge clk);
    bus1.req_valid = 2'b01; bus1.req_a = 2'b01; bus1.req_b = 2'b00;
    @(negedge clk);
    bus1.req_valid = 2'b00;
    @(negedge clk);
    chk("w1b_valid", bus1.res_valid, 1);
    chk("w1b_sum",   bus1.res_sum,   1);
    chk("w1b_cout",  bus1.res_cout,  0);
    @(negedge clk);
    chk("w1b_idle", bus1.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ha_serial_sched.md
Name: ha_serial_sched

Overview:
- Shares one bit-serial half-adder datapath between two requesters.
- The datapath is two half-adder stages plus a carry register.
- The block arbitrates round-robin, captures the winner's operands and runs the W-bit add LSB-first, one bit per clock.
- It returns the sum and carry-out with a valid/ready handshake. It sits between requesting logic and the output pins of the adder tile.

Parameters:
W, 8, operand/sum width in bits (legal range 1..16)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  2  per-requester request; bit i = requester i
req_a  input  2*W  operand A; requester i uses bits [i*W +: W]
req_b  input  2*W  operand B; same packing as req_a
req_ready  output  2  one-cycle accept pulse to the granted requester
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_sum  output  W  A+B mod 2^W
res_cout  output  1  carry out of bit W-1
res_id  output  1  index of the requester that owns the result
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, bit counter=0, carry=0, shift registers=0.
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, req_ready=0, busy=0.
  - Last-grant pointer=1, so requester 0 wins the first tie.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req_valid bit is set, grant g (combinational). A single active requester always wins. If both are active, g = ~last.
  - req_ready[g]=1 in that cycle only. req_ready is never high outside IDLE.
  - At the accepting edge: load A/B shift registers from requester g's slice, carry=0, counter=0, res_id=g, last=g. Go to RUN.
  - Operands are sampled only at the accepting edge. Later changes on req_a/req_b are ignored.
- RUN, each cycle:
  - s = a[0]^b[0]^carry (HA1: a^b; HA2: with carry).
  - carry_next = (a[0]&b[0]) | ((a[0]^b[0])&carry).
  - s shifts into the MSB of the sum register. A and B shift right. Counter increments.
  - When counter==W-1, the edge moves to DONE and latches res_cout=carry_next.
- Latency: res_valid rises W edges after the accepting edge. Exactly W RUN cycles, including W=1.
- DONE:
  - res_valid=1. res_sum, res_cout and res_id are held stable while res_valid=1 and res_ready=0.
  - The edge with res_valid&res_ready goes to IDLE and clears res_valid. res_sum, res_cout and res_id keep their values until the next result.
- Throughput: minimum W+2 cycles per op (accept, W RUN, DONE with res_ready=1). No accept can occur in the same cycle a result is consumed.
- A requester dropping req_valid before being granted is legal and simply loses the slot. The non-granted requester's pending request stays pending and wins the next IDLE arbitration.
- Reset asserted in any state aborts the operation immediately. No result is produced, and all outputs and the pointer return to reset values.
- res_ready while not in DONE has no effect.

Test Plan:
- W=8, req_valid=01, A0=0x5A, B0=0x3C, res_ready=1 -> req_ready=01 for one cycle; res_valid 8 edges later; res_sum=0x96, res_cout=0, res_id=0; busy high 9 cycles.
- Requester 1 alone, A1=0xFF, B1=0x01 -> res_sum=0x00, res_cout=1, res_id=1.
- req_valid=11 held, both with distinct operands -> grants alternate 0,1,0,1 across 4 ops; each res_id matches its operands' sum.
- Backpressure: res_ready=0 for 5 cycles in DONE, with req_a/req_b toggling -> res_valid, res_sum and res_cout stay stable, no req_ready pulse; consumed on first res_ready=1, IDLE next cycle.
- Assert rst mid-RUN (cycle 3 of 8) -> all outputs 0 asynchronously. After release with req_valid=11, requester 0 is granted first.
- W=1: A=1, B=1 -> res_sum=0, res_cout=1 one edge after accept. A=1, B=0 -> res_sum=1, res_cout=0.
